// File: rtl/stg_ma.sv
// Memory-access stage: one-cycle ALU pass-through plus single-outstanding load/store
// on a req/ack data port, with upstream stall and a timeout fault pulse.
module stg_ma #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 48,
    parameter int GP_IDX_W = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iw_valid,
    input  logic                iw_is_ld,
    input  logic                iw_is_st,
    input  logic [ADDR_W-1:0]   iw_addr,
    input  logic [DATA_W-1:0]   iw_result,
    input  logic [GP_IDX_W-1:0] iw_tgt_gp,
    input  logic                iw_tgt_gp_we,
    input  logic                iw_flush,
    output logic                ow_stall,
    output logic                ow_mem_req,
    output logic                ow_mem_we,
    output logic [ADDR_W-1:0]   ow_mem_addr,
    output logic [DATA_W-1:0]   ow_mem_wdata,
    input  logic                iw_mem_ack,
    input  logic [DATA_W-1:0]   iw_mem_rdata,
    output logic                ow_valid,
    output logic [DATA_W-1:0]   ow_result,
    output logic [GP_IDX_W-1:0] ow_tgt_gp,
    output logic                ow_tgt_gp_we,
    output logic                ow_fault
);

    // state | meaning
    // IDLE  | accepting instructions; ALU results pass through
    // WAIT  | memory request outstanding; upstream stalled
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic               kill;
    logic               lat_ld;
    logic               lat_we;
    logic [GP_IDX_W-1:0] lat_tgt;
    logic               start;
    logic               expire;
    logic               killed;

    assign start  = iw_valid && !iw_flush && (iw_is_ld || iw_is_st);
    assign expire = (timer == TMR_W'(TIMEOUT - 1));
    // A flush arriving in the completing cycle discards the result just like an earlier one.
    assign killed = kill || iw_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = WAIT;
            WAIT: if (iw_mem_ack || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ow_stall = (state == WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer        <= '0;
            kill         <= 1'b0;
            lat_ld       <= 1'b0;
            lat_we       <= 1'b0;
            lat_tgt      <= '0;
            ow_mem_req   <= 1'b0;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= '0;
            ow_mem_wdata <= '0;
            ow_valid     <= 1'b0;
            ow_result    <= '0;
            ow_tgt_gp    <= '0;
            ow_tgt_gp_we <= 1'b0;
            ow_fault     <= 1'b0;
        end else begin
            ow_valid     <= 1'b0;
            ow_tgt_gp_we <= 1'b0;
            ow_fault     <= 1'b0;
            case (state)
                IDLE: begin
                    kill  <= 1'b0;
                    timer <= '0;
                    if (start) begin
                        ow_mem_req   <= 1'b1;
                        ow_mem_we    <= iw_is_st;
                        ow_mem_addr  <= iw_addr;
                        ow_mem_wdata <= iw_result;
                        lat_ld       <= iw_is_ld;
                        lat_we       <= iw_tgt_gp_we;
                        lat_tgt      <= iw_tgt_gp;
                    end else if (iw_valid && !iw_flush) begin
                        ow_valid     <= 1'b1;
                        ow_result    <= iw_result;
                        ow_tgt_gp    <= iw_tgt_gp;
                        ow_tgt_gp_we <= iw_tgt_gp_we;
                    end
                end
                WAIT: begin
                    kill <= killed;
                    if (iw_mem_ack) begin
                        ow_mem_req <= 1'b0;
                        if (!killed) begin
                            ow_valid     <= 1'b1;
                            ow_result    <= lat_ld ? iw_mem_rdata : ow_mem_wdata;
                            ow_tgt_gp    <= lat_tgt;
                            ow_tgt_gp_we <= lat_ld && lat_we;
                        end
                    end else if (expire) begin
                        ow_mem_req <= 1'b0;
                        ow_fault   <= !killed;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ow_mem_req <= 1'b0;
            endcase
        end
    end

endmodule
